// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI4-Stream packet arbiter and its sink.
package axis_arb_pkg;

    localparam int unsigned C_DEFAULT_MAX_BEATS = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin pick: first requester after last_i, wrapping modulo C_NUM_REQ.
module rr_priority_picker
    import axis_arb_pkg::*;
#(
    parameter int unsigned C_NUM_REQ = 4
) (
    input  logic [C_NUM_REQ-1:0]         req_i,
    input  logic [clogb2(C_NUM_REQ)-1:0] last_i,
    output logic [C_NUM_REQ-1:0]         pick_o,
    output logic [clogb2(C_NUM_REQ)-1:0] idx_o,
    output logic                         valid_o
);

    localparam int unsigned IW = clogb2(C_NUM_REQ);

    logic [IW-1:0] cand;

    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        cand   = '0;
        for (int unsigned k = 1; k <= C_NUM_REQ; k++) begin
            cand = IW'((32'(last_i) + k) % C_NUM_REQ);
            if ((pick_o == '0) && req_i[cand]) begin
                pick_o[cand] = 1'b1;
                idx_o        = cand;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI4-Stream sink between
// C_NUM_REQ masters; a grant lasts until TLAST or a forced cut at C_MAX_BEATS.
module axis_rr_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_NUM_REQ            = 4,
    parameter int unsigned C_MAX_BEATS          = C_DEFAULT_MAX_BEATS
) (
    input  logic                                      S_AXIS_ACLK,
    input  logic                                      S_AXIS_ARESETN,
    input  logic [C_NUM_REQ*C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_NUM_REQ*C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic [C_NUM_REQ-1:0]                      S_AXIS_TLAST,
    input  logic [C_NUM_REQ-1:0]                      S_AXIS_TVALID,
    output logic [C_NUM_REQ-1:0]                      S_AXIS_TREADY,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]           M_AXIS_TDATA,
    output logic [C_S_AXIS_TDATA_WIDTH/8-1:0]         M_AXIS_TSTRB,
    output logic                                      M_AXIS_TLAST,
    output logic                                      M_AXIS_TVALID,
    input  logic                                      M_AXIS_TREADY,
    output logic [C_NUM_REQ-1:0]                      GRANT,
    output logic                                      BUSY,
    output logic                                      PKT_DONE,
    output logic                                      TRUNC,
    output logic [clogb2(C_MAX_BEATS):0]              BEAT_CNT
);

    localparam int unsigned W  = C_S_AXIS_TDATA_WIDTH;
    localparam int unsigned SW = C_S_AXIS_TDATA_WIDTH / 8;
    localparam int unsigned IW = clogb2(C_NUM_REQ);
    localparam int unsigned CW = clogb2(C_MAX_BEATS) + 1;

    state_t                 state_q, state_d;
    logic [C_NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic [IW-1:0]          last_q, last_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   trunc_q, trunc_d;

    logic [C_NUM_REQ-1:0]   pick_oh;
    logic [IW-1:0]          pick_idx;
    logic                   pick_valid;
    logic                   src_valid;
    logic                   src_last;
    logic                   forced_cut;
    logic                   accept;

    rr_priority_picker #(
        .C_NUM_REQ (C_NUM_REQ)
    ) u_picker (
        .req_i   (S_AXIS_TVALID),
        .last_i  (last_q),
        .pick_o  (pick_oh),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Granted slice steered to the sink; grant_q is zero outside XFER.
    always_comb begin
        M_AXIS_TDATA = '0;
        M_AXIS_TSTRB = '0;
        src_valid    = 1'b0;
        src_last     = 1'b0;
        for (int unsigned i = 0; i < C_NUM_REQ; i++) begin
            if (grant_q[i]) begin
                M_AXIS_TDATA = S_AXIS_TDATA[i*W +: W];
                M_AXIS_TSTRB = S_AXIS_TSTRB[i*SW +: SW];
                src_valid    = S_AXIS_TVALID[i];
                src_last     = S_AXIS_TLAST[i];
            end
        end
        forced_cut    = (cnt_q == CW'(C_MAX_BEATS - 1));
        M_AXIS_TVALID = (state_q == XFER) && src_valid;
        M_AXIS_TLAST  = (state_q == XFER) && (src_last || forced_cut);
        S_AXIS_TREADY = (state_q == XFER) ? (grant_q & {C_NUM_REQ{M_AXIS_TREADY}}) : '0;
        accept        = M_AXIS_TVALID && M_AXIS_TREADY;
    end

    // Next-state: arbitrate in IDLE, count beats and detect packet end in XFER.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        trunc_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = XFER;
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            XFER: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    if (M_AXIS_TLAST) begin
                        state_d = IDLE;
                        grant_d = '0;
                        last_d  = gidx_q;
                        done_d  = 1'b1;
                        trunc_d = !src_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == XFER);
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(C_NUM_REQ - 1);
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            trunc_q <= trunc_d;
        end
    end

    assign GRANT    = grant_q;
    assign BUSY     = busy_q;
    assign PKT_DONE = done_q;
    assign TRUNC    = trunc_q;
    assign BEAT_CNT = cnt_q;

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Self-checking bench for axis_rr_packet_arbiter: per-requester source queues,
// an expected-beat scoreboard on the sink side, and an arbitration vector table.
module tb_axis_rr_packet_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned W     = 32;
    localparam int unsigned SW    = W / 8;
    localparam int unsigned CW    = 4;
    localparam int unsigned DEPTH = 64;

    logic              clk;
    logic              rst_n;
    logic [N*W-1:0]    s_tdata;
    logic [N*SW-1:0]   s_tstrb;
    logic [N-1:0]      s_tlast;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tready;
    logic [W-1:0]      m_tdata;
    logic [SW-1:0]     m_tstrb;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic [N-1:0]      grant;
    logic              busy;
    logic              pkt_done;
    logic              trunc;
    logic [CW-1:0]     beat_cnt;

    axis_rr_packet_arbiter #(
        .C_S_AXIS_TDATA_WIDTH (W),
        .C_NUM_REQ            (N),
        .C_MAX_BEATS          (8)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rst_n),
        .S_AXIS_TDATA   (s_tdata),
        .S_AXIS_TSTRB   (s_tstrb),
        .S_AXIS_TLAST   (s_tlast),
        .S_AXIS_TVALID  (s_tvalid),
        .S_AXIS_TREADY  (s_tready),
        .M_AXIS_TDATA   (m_tdata),
        .M_AXIS_TSTRB   (m_tstrb),
        .M_AXIS_TLAST   (m_tlast),
        .M_AXIS_TVALID  (m_tvalid),
        .M_AXIS_TREADY  (m_tready),
        .GRANT          (grant),
        .BUSY           (busy),
        .PKT_DONE       (pkt_done),
        .TRUNC          (trunc),
        .BEAT_CNT       (beat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [W-1:0]  data;
        logic [SW-1:0] strb;
        logic          last;
        logic [N-1:0]  grant;
    } exp_t;

    typedef struct {
        int           prev;
        logic [N-1:0] mask;
        logic [N-1:0] exp_first;
    } arb_vec_t;

    exp_t          exp_q[$];
    logic [W-1:0]  src_data [N][DEPTH];
    logic [SW-1:0] src_strb [N][DEPTH];
    logic          src_last [N][DEPTH];
    int            src_len [N];
    int            src_ptr [N];

    int  passed, total;
    int  cyc, beats_seen, done_cnt, trunc_cnt, trunc_alone, rdy_viol;
    int  gap_cur, gap_min, gap_max;
    bit  prev_busy, seen_busy, sb_en, rdy_toggle;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic add_beat(input int r, input logic [W-1:0] d, input logic sl,
                            input logic el, input bit push);
        exp_t e;
        src_data[r][src_len[r]] = d;
        src_strb[r][src_len[r]] = d[SW-1:0] ^ SW'(9);
        src_last[r][src_len[r]] = sl;
        if (push) begin
            e.data  = d;
            e.strb  = d[SW-1:0] ^ SW'(9);
            e.last  = el;
            e.grant = N'(1) << r;
            exp_q.push_back(e);
        end
        src_len[r]++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i] = (src_ptr[i] < src_len[i]);
            s_tdata[i*W +: W]   = s_tvalid[i] ? src_data[i][src_ptr[i]] : '0;
            s_tstrb[i*SW +: SW] = s_tvalid[i] ? src_strb[i][src_ptr[i]] : '0;
            s_tlast[i]          = s_tvalid[i] ? src_last[i][src_ptr[i]] : 1'b0;
        end
        m_tready = rdy_toggle ? ((cyc % 2) == 1) : 1'b1;
    endtask

    // One cycle: drive after the edge, sample mid-cycle, retire handshakes.
    task automatic step();
        exp_t e, a;
        logic [N-1:0] rdy_exp;
        @(posedge clk);
        #1;
        cyc++;
        drive();
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_tvalid[i] && s_tready[i]) src_ptr[i]++;
        end
        if (m_tvalid && m_tready) begin
            beats_seen++;
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra_beat", 64'(m_tdata), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    a.data = m_tdata; a.strb = m_tstrb; a.last = m_tlast; a.grant = grant;
                    check("sb_beat", 64'(a), 64'(e));
                end
            end
        end
        if (pkt_done) done_cnt++;
        if (trunc) trunc_cnt++;
        if (trunc && !pkt_done) trunc_alone++;
        rdy_exp = busy ? (grant & {N{m_tready}}) : '0;
        if (s_tready !== rdy_exp) rdy_viol++;
        if (busy) begin
            if (!prev_busy && seen_busy) begin
                if (gap_cur < gap_min) gap_min = gap_cur;
                if (gap_cur > gap_max) gap_max = gap_cur;
            end
            seen_busy = 1'b1;
            gap_cur   = 0;
        end else begin
            gap_cur++;
        end
        prev_busy = busy;
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < N; i++) if (src_ptr[i] < src_len[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input bit need_idle, input int budget, input string name);
        int n;
        n = 0;
        while (n < budget && !(src_empty() && exp_q.size() == 0 &&
                               (!need_idle || (!busy && grant == '0 && n > 0)))) begin
            step();
            n++;
        end
        check(name, 64'(n < budget), 64'(1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) src_ptr[i] = src_len[i];
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        drive();
        rst_n = 1'b1;
        done_cnt = 0; trunc_cnt = 0; trunc_alone = 0; rdy_viol = 0;
        seen_busy = 1'b0; prev_busy = 1'b0; gap_cur = 0; gap_min = 1000; gap_max = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        arb_vec_t vec[6];
        int n, b0;

        vec[0] = '{0, 4'b1111, 4'b0010};
        vec[1] = '{1, 4'b0001, 4'b0001};
        vec[2] = '{2, 4'b1011, 4'b1000};
        vec[3] = '{3, 4'b0110, 4'b0010};
        vec[4] = '{0, 4'b0001, 4'b0001};
        vec[5] = '{2, 4'b0101, 4'b0001};

        passed = 0; total = 0; cyc = 0; beats_seen = 0;
        sb_en = 1'b1; rdy_toggle = 1'b0;
        for (int i = 0; i < N; i++) begin src_len[i] = 0; src_ptr[i] = 0; end
        rst_n = 1'b0;
        drive();
        #23;
        check("reset_regs", 64'({grant, busy, pkt_done, trunc, beat_cnt}), 64'(0));
        check("reset_bus", 64'({m_tvalid, m_tlast, s_tready}), 64'(0));
        do_reset();

        // Single requester 2, 3-beat packet.
        for (int k = 0; k < 3; k++) add_beat(2, W'(32'hA0 + k), k == 2, k == 2, 1'b1);
        step();
        check("t1_arb_cycle_grant", 64'(grant), 64'(0));
        step();
        check("t1_grant", 64'(grant), 64'(4'b0100));
        drain(1'b1, 20, "t1_drain");
        check("t1_pkt_done", 64'(done_cnt), 64'(1));
        check("t1_trunc", 64'(trunc_cnt), 64'(0));
        check("t1_beat_cnt", 64'(beat_cnt), 64'(3));

        // Arbitration vectors: set last_grant, then present a request mask.
        sb_en = 1'b0;
        for (int v = 0; v < 6; v++) begin
            add_beat(vec[v].prev, W'(32'h10 + v), 1'b1, 1'b1, 1'b0);
            drain(1'b1, 20, "arb_prev_drain");
            for (int r = 0; r < N; r++)
                if (vec[v].mask[r]) add_beat(r, W'(32'h20 + r), 1'b1, 1'b1, 1'b0);
            n = 0;
            do begin step(); n++; end while (grant == '0 && n < 6);
            check("arb_first_grant", 64'(grant), 64'(vec[v].exp_first));
            drain(1'b1, 40, "arb_drain");
        end
        sb_en = 1'b1;

        // Fairness: all four hold two 2-beat packets each.
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < N; r++)
                for (int k = 0; k < 2; k++)
                    add_beat(r, W'(32'hB000 + p*256 + r*16 + k), k == 1, k == 1, 1'b1);
        drain(1'b1, 60, "t2_drain");
        check("t2_pkt_count", 64'(done_cnt), 64'(8));
        check("t2_gap_min", 64'(gap_min), 64'(1));
        check("t2_gap_max", 64'(gap_max), 64'(1));

        // Forced cut: 11 beats with no TLAST from requester 1.
        do_reset();
        for (int k = 0; k < 11; k++) add_beat(1, W'(32'hC0 + k), 1'b0, k == 7, 1'b1);
        drain(1'b0, 40, "t3_drain");
        step(); step();
        check("t3_hold_grant", 64'({busy, grant}), 64'({1'b1, 4'b0010}));
        check("t3_beat_cnt", 64'(beat_cnt), 64'(3));
        check("t3_pkt_done", 64'(done_cnt), 64'(1));
        check("t3_trunc", 64'(trunc_cnt), 64'(1));
        check("t3_trunc_with_done", 64'(trunc_alone), 64'(0));

        // Toggling sink ready during requester 3's 4-beat packet.
        do_reset();
        rdy_toggle = 1'b1;
        for (int k = 0; k < 4; k++) add_beat(3, W'(32'hD0 + k), k == 3, k == 3, 1'b1);
        drain(1'b1, 40, "t4_drain");
        rdy_toggle = 1'b0;
        check("t4_tready_follow", 64'(rdy_viol), 64'(0));
        check("t4_beat_cnt", 64'(beat_cnt), 64'(4));
        check("t4_pkt_done", 64'(done_cnt), 64'(1));

        // Asynchronous reset after beat 2 of 5.
        do_reset();
        for (int k = 0; k < 5; k++) add_beat(2, W'(32'hE0 + k), k == 4, k == 4, 1'b1);
        b0 = beats_seen;
        n = 0;
        while (beats_seen - b0 < 2 && n < 10) begin step(); n++; end
        check("t5_two_beats", 64'(beats_seen - b0), 64'(2));
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_async_regs", 64'({grant, busy, pkt_done, trunc, beat_cnt}), 64'(0));
        check("t5_async_bus", 64'({m_tvalid, m_tlast, s_tready}), 64'(0));
        do_reset();
        add_beat(0, W'(32'hF0), 1'b1, 1'b1, 1'b1);
        add_beat(3, W'(32'hF3), 1'b1, 1'b1, 1'b1);
        drain(1'b1, 20, "t5_drain");
        check("t5_pkt_done", 64'(done_cnt), 64'(2));

        // Source TLAST on beat 8 coincides with the limit; then a 1-beat packet.
        do_reset();
        for (int k = 0; k < 8; k++) add_beat(0, W'(32'h60 + k), k == 7, k == 7, 1'b1);
        drain(1'b1, 30, "t6_drain");
        check("t6_pkt_done", 64'(done_cnt), 64'(1));
        check("t6_trunc", 64'(trunc_cnt), 64'(0));
        check("t6_beat_cnt", 64'(beat_cnt), 64'(8));
        add_beat(0, W'(32'h70), 1'b1, 1'b1, 1'b1);
        drain(1'b1, 20, "t6_single_drain");
        check("t6_single_cnt", 64'(beat_cnt), 64'(1));
        check("t6_single_done", 64'({done_cnt, trunc_cnt}), 64'({32'd2, 32'd0}));

        check("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
